// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor with a direct-mapped BTB, answering fetch queries one cycle later.
// Trained on ROB commit; the speculative history is restored from the architectural one on rollback.
module gshare_btb_predictor #(
  parameter int BHT_DEPTH = 64,
  parameter int CNT_WIDTH = 2,
  parameter int GHR_WIDTH = 6,
  parameter int BTB_DEPTH = 16,
  parameter int TAG_WIDTH = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          rdy,
  input  logic                                          query_valid,
  input  logic [31:0]                                   query_pc,
  output logic                                          pred_valid,
  output logic                                          pred_taken,
  output logic                                          pred_btb_hit,
  output logic [31:0]                                   pred_target,
  input  logic                                          spec_valid,
  input  logic                                          spec_taken,
  input  logic                                          commit_valid,
  input  logic                                          commit_is_branch,
  input  logic [31:0]                                   commit_pc,
  input  logic                                          commit_taken,
  input  logic [31:0]                                   commit_target,
  input  logic                                          rollback,
  output logic [((GHR_WIDTH > 0) ? GHR_WIDTH : 1)-1:0]  spec_ghr
);

  localparam int BI = $clog2(BHT_DEPTH);
  localparam int TI = $clog2(BTB_DEPTH);
  localparam int GW = (GHR_WIDTH > 0) ? GHR_WIDTH : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((2 ** (CNT_WIDTH - 1)) - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_MIN  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q [BHT_DEPTH];
  logic [CNT_WIDTH-1:0] cnt_d [BHT_DEPTH];
  logic [BTB_DEPTH-1:0] btb_vld_q, btb_vld_d;
  logic [TAG_WIDTH-1:0] btb_tag_q [BTB_DEPTH];
  logic [TAG_WIDTH-1:0] btb_tag_d [BTB_DEPTH];
  logic [31:0]          btb_tgt_q [BTB_DEPTH];
  logic [31:0]          btb_tgt_d [BTB_DEPTH];
  logic [GW-1:0]        spec_ghr_q, spec_ghr_d;
  logic [GW-1:0]        arch_ghr_q, arch_ghr_d;
  logic                 pred_valid_q, pred_valid_d;
  logic                 pred_taken_q, pred_taken_d;
  logic                 pred_hit_q, pred_hit_d;
  logic [31:0]          pred_tgt_q, pred_tgt_d;

  logic [BI-1:0]        q_bidx_s, c_bidx_s;
  logic [TI-1:0]        q_tidx_s, c_tidx_s;
  logic [TAG_WIDTH-1:0] q_tag_s, c_tag_s;
  logic                 q_hit_s;
  logic                 unused_s;

  // History is zero-extended; with GHR_WIDTH=0 both registers stay at zero.
  function automatic logic [BI-1:0] bht_index(input logic [31:0] pc, input logic [GW-1:0] ghr);
    return pc[BI+1:2] ^ BI'(ghr);
  endfunction

  function automatic logic [TAG_WIDTH-1:0] btb_tag(input logic [31:0] pc);
    return pc[TI+TAG_WIDTH+1:TI+2];
  endfunction

  assign q_bidx_s = bht_index(query_pc, spec_ghr_q);
  assign c_bidx_s = bht_index(commit_pc, arch_ghr_q);
  assign q_tidx_s = query_pc[TI+1:2];
  assign c_tidx_s = commit_pc[TI+1:2];
  assign q_tag_s  = btb_tag(query_pc);
  assign c_tag_s  = btb_tag(commit_pc);
  assign q_hit_s  = btb_vld_q[q_tidx_s] && (btb_tag_q[q_tidx_s] == q_tag_s);
  assign unused_s = ^{query_pc, commit_pc};

  // Prediction pipeline register: reads the tables as they stood before this edge.
  always_comb begin
    pred_valid_d = pred_valid_q;
    pred_taken_d = pred_taken_q;
    pred_hit_d   = pred_hit_q;
    pred_tgt_d   = pred_tgt_q;
    if (rdy) begin
      pred_valid_d = query_valid;
      if (query_valid) begin
        pred_taken_d = cnt_q[q_bidx_s][CNT_WIDTH-1];
        pred_hit_d   = q_hit_s;
        pred_tgt_d   = q_hit_s ? btb_tgt_q[q_tidx_s] : 32'h0000_0000;
      end else begin
        pred_taken_d = 1'b0;
        pred_hit_d   = 1'b0;
        pred_tgt_d   = 32'h0000_0000;
      end
    end else begin
      pred_valid_d = pred_valid_q;
    end
  end

  // Commit training of counters, architectural history and BTB.
  always_comb begin
    cnt_d      = cnt_q;
    btb_vld_d  = btb_vld_q;
    btb_tag_d  = btb_tag_q;
    btb_tgt_d  = btb_tgt_q;
    arch_ghr_d = arch_ghr_q;
    if (rdy && commit_valid && commit_is_branch) begin
      if (commit_taken) begin
        if (cnt_q[c_bidx_s] != CNT_MAX) begin
          cnt_d[c_bidx_s] = cnt_q[c_bidx_s] + CNT_ONE;
        end else begin
          cnt_d[c_bidx_s] = CNT_MAX;
        end
      end else begin
        if (cnt_q[c_bidx_s] != CNT_MIN) begin
          cnt_d[c_bidx_s] = cnt_q[c_bidx_s] - CNT_ONE;
        end else begin
          cnt_d[c_bidx_s] = CNT_MIN;
        end
      end
      if (GHR_WIDTH > 0) begin
        arch_ghr_d = GW'({arch_ghr_q, commit_taken});
      end else begin
        arch_ghr_d = {GW{1'b0}};
      end
    end else begin
      arch_ghr_d = arch_ghr_q;
    end
    if (rdy && commit_valid && commit_taken) begin
      btb_vld_d[c_tidx_s] = 1'b1;
      btb_tag_d[c_tidx_s] = c_tag_s;
      btb_tgt_d[c_tidx_s] = commit_target;
    end else begin
      btb_vld_d = btb_vld_q;
    end
  end

  // Speculative history: rollback (after any same-cycle commit) beats spec_valid.
  always_comb begin
    spec_ghr_d = spec_ghr_q;
    if (!rdy) begin
      spec_ghr_d = spec_ghr_q;
    end else if (rollback) begin
      spec_ghr_d = arch_ghr_d;
    end else if (spec_valid && (GHR_WIDTH > 0)) begin
      spec_ghr_d = GW'({spec_ghr_q, spec_taken});
    end else begin
      spec_ghr_d = spec_ghr_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_hit_q   <= 1'b0;
      pred_tgt_q   <= 32'h0000_0000;
      spec_ghr_q   <= {GW{1'b0}};
      arch_ghr_q   <= {GW{1'b0}};
      btb_vld_q    <= {BTB_DEPTH{1'b0}};
      for (int i = 0; i < BHT_DEPTH; i++) begin
        cnt_q[i] <= CNT_INIT;
      end
      for (int j = 0; j < BTB_DEPTH; j++) begin
        btb_tag_q[j] <= {TAG_WIDTH{1'b0}};
        btb_tgt_q[j] <= 32'h0000_0000;
      end
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_hit_q   <= pred_hit_d;
      pred_tgt_q   <= pred_tgt_d;
      spec_ghr_q   <= spec_ghr_d;
      arch_ghr_q   <= arch_ghr_d;
      btb_vld_q    <= btb_vld_d;
      cnt_q        <= cnt_d;
      btb_tag_q    <= btb_tag_d;
      btb_tgt_q    <= btb_tgt_d;
    end
  end

  assign pred_valid   = pred_valid_q;
  assign pred_taken   = pred_taken_q;
  assign pred_btb_hit = pred_hit_q;
  assign pred_target  = pred_tgt_q;
  assign spec_ghr     = spec_ghr_q;

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Self-checking bench: a gshare instance (defaults) and a bimodal instance (GHR_WIDTH=0) share stimulus.
// Table rows carry expected bimodal predictions through a scoreboard queue; history/reset use short sequences.
module tb_gshare_btb_predictor;

  logic        clk, rst, rdy, query_valid, spec_valid, spec_taken;
  logic        commit_valid, commit_is_branch, commit_taken, rollback;
  logic [31:0] query_pc, commit_pc, commit_target;
  logic        d_valid, d_taken, d_hit, b_valid, b_taken, b_hit;
  logic [31:0] d_target, b_target;
  logic [5:0]  d_ghr;
  logic [0:0]  b_ghr;

  gshare_btb_predictor u_dut (
    .clk(clk), .rst(rst), .rdy(rdy), .query_valid(query_valid), .query_pc(query_pc),
    .pred_valid(d_valid), .pred_taken(d_taken), .pred_btb_hit(d_hit), .pred_target(d_target),
    .spec_valid(spec_valid), .spec_taken(spec_taken), .commit_valid(commit_valid),
    .commit_is_branch(commit_is_branch), .commit_pc(commit_pc), .commit_taken(commit_taken),
    .commit_target(commit_target), .rollback(rollback), .spec_ghr(d_ghr));

  gshare_btb_predictor #(.GHR_WIDTH(0)) u_bim (
    .clk(clk), .rst(rst), .rdy(rdy), .query_valid(query_valid), .query_pc(query_pc),
    .pred_valid(b_valid), .pred_taken(b_taken), .pred_btb_hit(b_hit), .pred_target(b_target),
    .spec_valid(spec_valid), .spec_taken(spec_taken), .commit_valid(commit_valid),
    .commit_is_branch(commit_is_branch), .commit_pc(commit_pc), .commit_taken(commit_taken),
    .commit_target(commit_target), .rollback(rollback), .spec_ghr(b_ghr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, qv;
    logic [31:0] qpc;
    logic        cv, cbr, ct;
    logic [31:0] cpc, ctgt;
    logic        ev, et, eh;
    logic [31:0] etgt;
  } vec_t;

  typedef struct {
    logic        v, t, h;
    logic [31:0] tgt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  vec_t v;
  exp_t e;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic qv, input logic [31:0] qpc,
                     input logic cv, input logic cbr, input logic ct,
                     input logic [31:0] cpc, input logic [31:0] ctgt,
                     input logic ev, input logic et, input logic eh, input logic [31:0] etgt);
    vec_t x;
    x = '{rdy: r, qv: qv, qpc: qpc, cv: cv, cbr: cbr, ct: ct, cpc: cpc, ctgt: ctgt,
          ev: ev, et: et, eh: eh, etgt: etgt};
    tbl.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_pred(input string nm, input logic bim, input logic ev, input logic et,
                          input logic eh, input logic [31:0] etgt);
    if (bim) begin
      chk({nm, ".valid"}, {31'd0, b_valid}, {31'd0, ev});
      chk({nm, ".taken"}, {31'd0, b_taken}, {31'd0, et});
      chk({nm, ".hit"}, {31'd0, b_hit}, {31'd0, eh});
      chk({nm, ".target"}, b_target, etgt);
    end else begin
      chk({nm, ".valid"}, {31'd0, d_valid}, {31'd0, ev});
      chk({nm, ".taken"}, {31'd0, d_taken}, {31'd0, et});
      chk({nm, ".hit"}, {31'd0, d_hit}, {31'd0, eh});
      chk({nm, ".target"}, d_target, etgt);
    end
  endtask

  task automatic query(input logic [31:0] pc);
    query_valid = 1'b1;
    query_pc    = pc;
    tick();
    query_valid = 1'b0;
  endtask

  task automatic commit(input logic br, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    commit_valid = 1'b1; commit_is_branch = br; commit_pc = pc; commit_taken = t; commit_target = tgt;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic spec_shift(input int n);
    spec_valid = 1'b1; spec_taken = 1'b1;
    for (int k = 0; k < n; k++) tick();
    spec_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; query_valid = 1'b0; query_pc = 32'h0;
    spec_valid = 1'b0; spec_taken = 1'b0; rollback = 1'b0;
    commit_valid = 1'b0; commit_is_branch = 1'b0; commit_pc = 32'h0;
    commit_taken = 1'b0; commit_target = 32'h0;

    // bimodal instance: pc 0x40 -> counter 0x10, BTB 0 tag 1; pc 0x80 -> counter 0x20, BTB 0 tag 2
    add(1, 1, 32'h40, 1, 1, 1, 32'h40, 32'h20, 1, 0, 0, 32'h0);
    add(1, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h20);
    add(1, 0, 32'h0, 1, 1, 1, 32'h40, 32'h20, 0, 0, 0, 32'h0);
    add(1, 0, 32'h0, 1, 1, 0, 32'h40, 32'h20, 0, 0, 0, 32'h0);
    add(1, 0, 32'h0, 1, 1, 0, 32'h40, 32'h20, 0, 0, 0, 32'h0);
    add(1, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h20);
    for (int k = 0; k < 5; k++) add(1, 0, 32'h0, 1, 1, 1, 32'h40, 32'h20, 0, 0, 0, 32'h0);
    add(1, 0, 32'h0, 1, 1, 0, 32'h40, 32'h20, 0, 0, 0, 32'h0);
    add(1, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h20);
    for (int k = 0; k < 2; k++) add(1, 0, 32'h0, 1, 1, 0, 32'h40, 32'h20, 0, 0, 0, 32'h0);
    add(1, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h20);
    for (int k = 0; k < 2; k++) add(1, 0, 32'h0, 1, 1, 0, 32'h40, 32'h20, 0, 0, 0, 32'h0);
    add(1, 0, 32'h0, 1, 1, 1, 32'h40, 32'h20, 0, 0, 0, 32'h0);
    add(1, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h20);
    add(1, 0, 32'h0, 1, 1, 1, 32'h40, 32'h20, 0, 0, 0, 32'h0);
    add(1, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h20);
    add(0, 0, 32'h0, 1, 1, 0, 32'h40, 32'h20, 1, 1, 1, 32'h20);
    add(1, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h20);
    add(0, 1, 32'h80, 0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h20);
    add(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    add(1, 0, 32'h0, 1, 0, 1, 32'h80, 32'h100, 0, 0, 0, 32'h0);
    add(1, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h0);
    add(1, 1, 32'h80, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h100);
    add(1, 0, 32'h0, 1, 1, 0, 32'h80, 32'h444, 0, 0, 0, 32'h0);
    add(1, 1, 32'h80, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h100);
    add(1, 0, 32'h0, 1, 1, 0, 32'h40, 32'h20, 0, 0, 0, 32'h0);
    add(1, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h0);
    for (int k = 0; k < 2; k++) add(1, 0, 32'h0, 1, 1, 1, 32'h40, 32'h20, 0, 0, 0, 32'h0);
    add(1, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h20);
    add(1, 1, 32'h1040, 0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h0);
    add(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);

    #12;
    chk_pred("rst_dut", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_pred("rst_bim", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_spec_ghr", {26'd0, d_ghr}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    query(32'h1000);
    chk_pred("first_q_dut", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_pred("first_q_bim", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("first_q_drop", {31'd0, d_valid}, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      rdy = v.rdy; query_valid = v.qv; query_pc = v.qpc;
      commit_valid = v.cv; commit_is_branch = v.cbr; commit_taken = v.ct;
      commit_pc = v.cpc; commit_target = v.ctgt;
      sb.push_back('{v: v.ev, t: v.et, h: v.eh, tgt: v.etgt});
      tick();
      e = sb.pop_front();
      chk($sformatf("row%0d.valid", i), {31'd0, b_valid}, {31'd0, e.v});
      if (e.v) begin
        chk($sformatf("row%0d.taken", i), {31'd0, b_taken}, {31'd0, e.t});
        chk($sformatf("row%0d.hit", i), {31'd0, b_hit}, {31'd0, e.h});
        chk($sformatf("row%0d.target", i), b_target, e.tgt);
      end
    end
    rdy = 1'b1; query_valid = 1'b0; commit_valid = 1'b0;

    // asynchronous reset while a prediction is on the outputs
    query_valid = 1'b1; query_pc = 32'h40;
    @(posedge clk);
    #2;
    chk("pend_valid", {31'd0, b_valid}, 32'h1);
    rst = 1'b0;
    #1;
    chk("async_valid_bim", {31'd0, b_valid}, 32'h0);
    chk("async_valid_dut", {31'd0, d_valid}, 32'h0);
    chk("async_target_bim", b_target, 32'h0);
    query_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    query(32'h40);
    chk_pred("post_rst_bim", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_pred("post_rst_dut", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // history behaviour on the gshare instance
    spec_shift(3);
    chk("ghr_shift3", {26'd0, d_ghr}, 32'h7);
    chk("ghr_bimodal", {31'd0, b_ghr}, 32'h0);
    query(32'h40);
    chk_pred("ghr_q_cold", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    rollback = 1'b1; spec_valid = 1'b1; spec_taken = 1'b1;
    tick();
    rollback = 1'b0; spec_valid = 1'b0;
    chk("rollback_over_spec", {26'd0, d_ghr}, 32'h0);
    commit(1'b1, 32'h5C, 1'b1, 32'h200);
    spec_shift(3);
    chk("ghr_shift3b", {26'd0, d_ghr}, 32'h7);
    query(32'h40);
    chk_pred("ghr_idx17", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    query(32'h5C);
    chk_pred("ghr_idx10", 1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    rollback = 1'b1;
    tick();
    chk("rollback_arch1", {26'd0, d_ghr}, 32'h1);
    commit_valid = 1'b1; commit_is_branch = 1'b1; commit_pc = 32'h40; commit_taken = 1'b0;
    commit_target = 32'h0;
    tick();
    rollback = 1'b0; commit_valid = 1'b0;
    chk("rollback_with_commit", {26'd0, d_ghr}, 32'h2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gshare_btb_predictor.md
Name: gshare_btb_predictor

Overview:
- Parametrised successor to the fetch-stage 2-bit predictor: a gshare direction predictor plus a direct-mapped branch target buffer (BTB).
- Sits beside IFetch/pc_manager. Answers fetch queries one cycle later with direction, BTB hit and target.
- Maintains a speculative and an architectural global history register (GHR). It is trained on ROB commit and restored on ROB rollback.

Parameters:
- BHT_DEPTH, 64: counter table entries; power of 2; index width BI = log2(BHT_DEPTH).
- CNT_WIDTH, 2: saturating counter width, ≥1.
- GHR_WIDTH, 6: history bits, 0..BI; 0 = pure bimodal.
- BTB_DEPTH, 16: BTB entries; power of 2; index width TI = log2(BTB_DEPTH).
- TAG_WIDTH, 8: BTB tag bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- rdy  in  1  global ready; 0 freezes all state and outputs.
- query_valid  in  1  fetch query strobe.
- query_pc  in  32  PC being fetched.
- pred_valid  out  1  prediction valid; one-cycle pulse.
- pred_taken  out  1  predicted direction.
- pred_btb_hit  out  1  BTB tag match.
- pred_target  out  32  BTB target (0 on miss).
- spec_valid  in  1  a predicted B-type branch left fetch.
- spec_taken  in  1  its predicted direction.
- commit_valid  in  1  ROB commits a B-type or JAL.
- commit_is_branch  in  1  1 = B-type, 0 = JAL.
- commit_pc  in  32  committed instruction PC.
- commit_taken  in  1  actual outcome (JAL: 1).
- commit_target  in  32  actual target.
- rollback  in  1  ROB flush.
- spec_ghr  out  GHR_WIDTH (min 1)  current speculative GHR, for debug and bench.

Behaviour:
- Reset (rst=0, async) values:
  - pred_valid=0, pred_taken=0, pred_btb_hit=0, pred_target=0.
  - spec and arch GHR = 0.
  - Every counter = 2^(CNT_WIDTH-1)-1 (weakly not-taken; 01 for 2-bit).
  - All BTB valid bits = 0.
  - Reset mid-query drops the pending prediction.
- rdy=0: no state changes; outputs hold.
- Indexing:
  - bht_idx = pc[BI+1:2] XOR zero-extended GHR.
  - btb_idx = pc[TI+1:2].
  - tag = pc[TI+TAG_WIDTH+1:TI+2].
- Query latency 1:
  - query_valid=1 at edge N → at N+1: pred_valid=1, pred_taken = counter MSB, pred_btb_hit = valid && tag match, pred_target = stored target or 0.
  - Reads use the table and spec GHR values before edge N's updates (read-before-write).
  - pred_valid returns to 0 on the next edge without a query.
- Speculative history:
  - spec_valid → spec GHR <= {spec GHR[GHR_WIDTH-2:0], spec_taken}.
  - Ignored when GHR_WIDTH=0.
- Commit:
  - B-type:
    - Counter at bht_idx (computed with arch GHR before this commit) saturates up if taken, down otherwise; no wrap.
    - Arch GHR shifts in commit_taken.
  - Any commit with commit_taken=1: BTB[btb_idx] <= {valid=1, tag, commit_target}.
  - Not-taken branches leave the BTB unchanged.
  - JAL never touches counters or GHR.
- Rollback:
  - spec GHR <= arch GHR value after any same-cycle commit.
  - Rollback overrides a same-cycle spec_valid.
  - Query outputs are unaffected; IFetch discards them.
- Simultaneous events: a commit and a query to the same entry in the same cycle → the query sees the old value. The new value is visible from the next query.
- No internal FSM beyond the pipeline register; tables are flop arrays.

Test Plan:
1. Reset: release rst, query_pc=0x1000 → next cycle pred_valid=1, pred_taken=0, pred_btb_hit=0, pred_target=0; following cycle pred_valid=0.
2. Training (GHR_WIDTH=0): two taken commits of pc=0x40, target=0x20 → query 0x40 gives taken=1, hit=1, target=0x20. Two not-taken commits → taken=0, hit=1.
3. Saturation (GHR_WIDTH=0): five taken commits of 0x40 then one not-taken → still taken=1. Two more not-taken → taken=0; repeated not-taken stays 0 (counter at 00, no wrap).
4. History (defaults): spec_valid with taken=1 ×3 → spec_ghr=6'b000111; query 0x40 reads BHT index 0x10^0x07=0x17. rollback with arch GHR=0 and same-cycle spec_valid → spec_ghr=0.
5. BTB alias (BTB_DEPTH=16): taken commit 0x40→0x20, then taken commit 0x80→0x100 (same index 0, different tag) → query 0x40 hit=0, target=0; query 0x80 hit=1, target=0x100.
6. Async reset mid-operation: drop rst between edges during a pending query → pred_valid=0 immediately. After release, the trained pc 0x40 predicts not-taken with hit=0.
